// File: rtl/buzzer_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : buzzer_seq_ctrl                                              |
// | Brief   : Square-wave buzzer sequencer (short/long/burst/continuous)   |
// |           with busy/done status. Optional macro BUZZER_MUTE_EN adds    |
// |           a BUZZER_MUTE input that forces the tone output low.         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module buzzer_seq_ctrl #(
    parameter int unsigned TONE_DIV   = 12500,
    parameter int unsigned TONE_HIGH  = 6250,
    parameter int unsigned SHORT_TIME = 4,
    parameter int unsigned LONG_TIME  = 255,
    parameter int unsigned ON_TIME    = 40,
    parameter int unsigned OFF_TIME   = 40,
    parameter int unsigned BEEP_W     = 4
) (
    input  logic              CLK_LOW,
    input  logic              RST_N,
    input  logic              BUZZER_EN,
    input  logic [1:0]        BUZZER_MODE,
    input  logic [BEEP_W-1:0] BUZZER_CNT,
`ifdef BUZZER_MUTE_EN
    input  logic              BUZZER_MUTE,
`endif
    output logic              BUZZER_ON_OFF,
    output logic              BUZZER_BUSY,
    output logic              BUZZER_DONE
);

    localparam int unsigned CNT_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(TONE_DIV - 1);
    localparam logic [CNT_W-1:0] c_tone_high = CNT_W'(TONE_HIGH);
    localparam logic [7:0]       c_short     = 8'(SHORT_TIME);
    localparam logic [7:0]       c_long      = 8'(LONG_TIME);
    localparam logic [7:0]       c_on        = 8'(ON_TIME);
    localparam logic [7:0]       c_off       = 8'(OFF_TIME);

    localparam logic [1:0] c_mode_short = 2'b00;
    localparam logic [1:0] c_mode_long  = 2'b01;
    localparam logic [1:0] c_mode_burst = 2'b10;
    localparam logic [1:0] c_mode_cont  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_TONE = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t            r_state;
    logic              r_en;
    logic [1:0]        r_mode;
    logic [BEEP_W-1:0] r_beep;
    logic [CNT_W-1:0]  r_cnt_clk;
    logic [7:0]        r_per_cnt;
    logic              r_on_off;
    logic              r_busy;
    logic              r_done;

    logic              w_start;
    logic              w_wrap;
    logic [7:0]        w_per_nxt;
    logic [7:0]        w_target;
    logic [BEEP_W-1:0] w_cnt_in;
    logic              w_tone;
    logic              w_mute;

    assign w_start   = BUZZER_EN && !r_en && (r_state == ST_IDLE);
    assign w_wrap    = (r_cnt_clk == c_cnt_last);
    assign w_per_nxt = r_per_cnt + 8'd1;
    // A zero beep count behaves as a single beep.
    assign w_cnt_in  = (BUZZER_CNT == '0) ? BEEP_W'(1) : BUZZER_CNT;
    assign w_tone    = (r_state == ST_TONE) && (r_cnt_clk != '0) &&
                       (r_cnt_clk <= c_tone_high);

`ifdef BUZZER_MUTE_EN
    assign w_mute = BUZZER_MUTE;
`else
    assign w_mute = 1'b0;
`endif

    always_comb begin
        w_target = c_short;
        case (r_mode)
            c_mode_short: w_target = c_short;
            c_mode_long:  w_target = c_long;
            c_mode_burst: w_target = c_on;
            default:      w_target = c_short;
        endcase
    end

    always_ff @(posedge CLK_LOW or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_mode    <= 2'b00;
            r_beep    <= '0;
            r_cnt_clk <= '0;
            r_per_cnt <= 8'd0;
            r_on_off  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_en     <= BUZZER_EN;
            r_done   <= 1'b0;
            r_on_off <= w_tone && !w_mute;

            case (r_state)
                ST_IDLE: begin
                    r_cnt_clk <= '0;
                    if (w_start) begin
                        r_mode    <= BUZZER_MODE;
                        r_beep    <= w_cnt_in;
                        r_per_cnt <= 8'd0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_TONE;
                    end
                end

                ST_TONE: begin
                    if (w_wrap) begin
                        r_cnt_clk <= '0;
                        r_per_cnt <= w_per_nxt;
                        // Continuous mode ends only on a period boundary.
                        if (r_mode == c_mode_cont) begin
                            if (!BUZZER_EN) begin
                                r_state   <= ST_IDLE;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                                r_per_cnt <= 8'd0;
                            end
                        end else if (w_per_nxt == w_target) begin
                            r_per_cnt <= 8'd0;
                            if ((r_mode == c_mode_burst) && (r_beep > BEEP_W'(1))) begin
                                r_beep  <= r_beep - BEEP_W'(1);
                                r_state <= ST_GAP;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end else begin
                        r_cnt_clk <= r_cnt_clk + CNT_W'(1);
                    end
                end

                ST_GAP: begin
                    if (w_wrap) begin
                        r_cnt_clk <= '0;
                        if (w_per_nxt == c_off) begin
                            r_per_cnt <= 8'd0;
                            r_state   <= ST_TONE;
                        end else begin
                            r_per_cnt <= w_per_nxt;
                        end
                    end else begin
                        r_cnt_clk <= r_cnt_clk + CNT_W'(1);
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_cnt_clk <= '0;
                    r_per_cnt <= 8'd0;
                end
            endcase
        end
    end

    assign BUZZER_ON_OFF = r_on_off;
    assign BUZZER_BUSY   = r_busy;
    assign BUZZER_DONE   = r_done;

endmodule
`default_nettype wire
